// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// pkg_config: shared configuration for the RV32I integer ALU.
//   DATA_WIDTH   - operand/result width (only 32 is supported)
//   OP_ALU_*     - 6-bit operation encodings driven by the decoder
//   alu_op_t     - operation code type
//   shift_mode_t - selects the shifter function inside alu_shifter
// ----------------------------------------------------------------------------
package pkg_config;

    localparam int DATA_WIDTH = 32;

    typedef logic [5:0] alu_op_t;

    localparam alu_op_t OP_ALU_ADD  = 6'd0;
    localparam alu_op_t OP_ALU_SUB  = 6'd1;
    localparam alu_op_t OP_ALU_AND  = 6'd2;
    localparam alu_op_t OP_ALU_OR   = 6'd3;
    localparam alu_op_t OP_ALU_XOR  = 6'd4;
    localparam alu_op_t OP_ALU_SLT  = 6'd5;
    localparam alu_op_t OP_ALU_SLTU = 6'd6;
    localparam alu_op_t OP_ALU_SLL  = 6'd7;
    localparam alu_op_t OP_ALU_SRL  = 6'd8;
    localparam alu_op_t OP_ALU_SRA  = 6'd9;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// ----------------------------------------------------------------------------
// alu_shifter: combinational barrel shifter for SLL / SRL / SRA.
//   i_a      - value to shift
//   i_shamt  - shift amount (0..31)
//   i_mode   - SHIFT_SLL, SHIFT_SRL or SHIFT_SRA
//   o_result - shifted value
// ----------------------------------------------------------------------------
module alu_shifter
    import pkg_config::*;
(
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [4:0]            i_shamt,
    input  shift_mode_t           i_mode,
    output logic [DATA_WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_mode)
            SHIFT_SLL: o_result = i_a << i_shamt;
            SHIFT_SRL: o_result = i_a >> i_shamt;
            // Signed cast makes >>> replicate i_a[31] into the vacated bits.
            SHIFT_SRA: o_result = $signed(i_a) >>> i_shamt;
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu: RV32I integer ALU with a registered result (one clock of latency).
//   clk_i    - system clock, rising edge
//   rst_i    - synchronous active-high reset, clears c_o
//   alu_op_i - operation select (OP_ALU_* from pkg_config)
//   a_i      - operand A (rs1 or PC)
//   b_i      - operand B (rs2 or immediate; shift amount in b_i[4:0])
//   c_o      - registered result; unknown op codes yield zero
// ----------------------------------------------------------------------------
module alu
    import pkg_config::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5:0]            alu_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] c_o
);

    logic                  w_is_sub;
    logic [DATA_WIDTH-1:0] w_b_addend;
    logic [DATA_WIDTH:0]   w_addsub;
    logic                  w_lt_unsigned;
    logic                  w_lt_signed;
    shift_mode_t           w_shift_mode;
    logic [DATA_WIDTH-1:0] w_shift_result;
    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] r_result;

    // One adder serves ADD, SUB and both compares: subtraction is a + ~b + 1.
    assign w_is_sub   = (alu_op_i == OP_ALU_SUB) || (alu_op_i == OP_ALU_SLT) ||
                        (alu_op_i == OP_ALU_SLTU);
    assign w_b_addend = w_is_sub ? ~b_i : b_i;
    assign w_addsub   = {1'b0, a_i} + {1'b0, w_b_addend} +
                        {{DATA_WIDTH{1'b0}}, w_is_sub};

    // During a subtract the carry out is set exactly when a >= b (unsigned).
    assign w_lt_unsigned = ~w_addsub[DATA_WIDTH];
    // With differing signs the negative operand is the smaller one; with
    // equal signs the difference cannot overflow, so its sign bit decides.
    assign w_lt_signed   = (a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1]) ?
                           a_i[DATA_WIDTH-1] : w_addsub[DATA_WIDTH-1];

    always_comb begin
        w_shift_mode = SHIFT_SLL;
        case (alu_op_i)
            OP_ALU_SRL: w_shift_mode = SHIFT_SRL;
            OP_ALU_SRA: w_shift_mode = SHIFT_SRA;
            default:    w_shift_mode = SHIFT_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .i_a      (a_i),
        .i_shamt  (b_i[4:0]),
        .i_mode   (w_shift_mode),
        .o_result (w_shift_result)
    );

    always_comb begin
        w_result = '0;
        case (alu_op_i)
            OP_ALU_ADD,
            OP_ALU_SUB:  w_result = w_addsub[DATA_WIDTH-1:0];
            OP_ALU_AND:  w_result = a_i & b_i;
            OP_ALU_OR:   w_result = a_i | b_i;
            OP_ALU_XOR:  w_result = a_i ^ b_i;
            OP_ALU_SLT:  w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_signed};
            OP_ALU_SLTU: w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_unsigned};
            OP_ALU_SLL,
            OP_ALU_SRL,
            OP_ALU_SRA:  w_result = w_shift_result;
            default:     w_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else begin
            r_result <= w_result;
        end
    end

    assign c_o = r_result;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import pkg_config::*;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  alu_op_i = OP_ALU_ADD;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic [31:0] c_o;

    always #5 clk_i = ~clk_i;

    alu dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .alu_op_i (alu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .c_o      (c_o)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;
    int          n_vec  = 0;
    int          n_miss = 0;

    // Reference model: results computed from the instruction definitions
    // with plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [5:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        logic [31:0] p;
        s = b % 32;
        p = 32'd1 << s;
        case (op)
            6'd0: return a + b;
            6'd1: return a - b;
            6'd2: return a & b;
            6'd3: return a | b;
            6'd4: return a ^ b;
            6'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'd6: return (a < b) ? 32'd1 : 32'd0;
            6'd7: return a * p;
            6'd8: return a / p;
            6'd9: return a[31] ? ~((~a) / p) : (a / p);
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Apply one operation: inputs change after a falling edge, the old result
    // must still be visible, and the new result must appear right after the
    // next rising edge.
    task automatic step(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string tag);
        logic [31:0] want;
        @(negedge clk_i);
        rst_i    = 1'b0;
        alu_op_i = op;
        a_i      = a;
        b_i      = b;
        #1;
        n_vec++;
        assert (c_o === last_exp) else begin
            n_miss++;
            $error("FAIL %s_hold: c_o=%h expected %h", tag, c_o, last_exp);
        end
        exp_q.push_back(exp);
        @(posedge clk_i);
        #1;
        want = exp_q.pop_front();
        n_vec++;
        assert (c_o === want) else begin
            n_miss++;
            $error("FAIL %s: op=%0d a=%h b=%h c_o=%h expected %h",
                   tag, op, a, b, c_o, want);
        end
        last_exp = want;
    endtask

    task automatic reset_cycles(input int n, input logic [5:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input string tag);
        @(negedge clk_i);
        rst_i    = 1'b1;
        alu_op_i = op;
        a_i      = a;
        b_i      = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            n_vec++;
            assert (c_o === 32'd0) else begin
                n_miss++;
                $error("FAIL %s: c_o=%h expected %h", tag, c_o, 32'd0);
            end
        end
        last_exp = 32'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset held for two cycles while an ADD is presented.
        reset_cycles(2, OP_ALU_ADD, 32'd5, 32'd3, "reset");
        step(OP_ALU_ADD, 32'd5, 32'd3, 32'h0000_0008, "rst_release");

        // Arithmetic, including wrap-around.
        step(OP_ALU_ADD, 32'd1, 32'd1, 32'h0000_0002, "add_1_1");
        step(OP_ALU_SUB, 32'd1, 32'd1, 32'h0000_0000, "sub_1_1");
        step(OP_ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_ovf");
        step(OP_ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_unf");

        // Logic.
        step(OP_ALU_AND, 32'h0000_0101, 32'h0001_0001, 32'h0000_0001, "and");
        step(OP_ALU_OR,  32'h0000_0101, 32'h0001_0001, 32'h0001_0101, "or");
        step(OP_ALU_XOR, 32'h0000_0101, 32'h0001_0001, 32'h0001_0100, "xor");

        // Compares.
        step(OP_ALU_SLT,  32'hFFFF_FFF0, 32'h0000_0010, 32'd1, "slt_neg");
        step(OP_ALU_SLTU, 32'h0000_0010, 32'hFFFF_FFF0, 32'd1, "sltu_lt");
        step(OP_ALU_SLTU, 32'hFFFF_FFF0, 32'h0000_0010, 32'd0, "sltu_ge");
        step(OP_ALU_SLT,  32'h0000_0010, 32'hFFFF_FFF0, 32'd0, "slt_pos");
        step(OP_ALU_SLT,  32'h1234_5678, 32'h1234_5678, 32'd0, "slt_eq");
        step(OP_ALU_SLTU, 32'h1234_5678, 32'h1234_5678, 32'd0, "sltu_eq");

        // Shifts.
        step(OP_ALU_SLL, 32'd1, 32'd4, 32'h0000_0010, "sll_4");
        step(OP_ALU_SRL, 32'h0000_0100, 32'd1, 32'h0000_0080, "srl_1");
        step(OP_ALU_SRA, 32'hFFFF_F000, 32'd4, 32'hFFFF_FF00, "sra_4");
        step(OP_ALU_SRA, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, "sra_31");
        step(OP_ALU_SRL, 32'h8000_0000, 32'h1F, 32'h0000_0001, "srl_31");
        step(OP_ALU_SLL, 32'd1, 32'h0000_0021, 32'h0000_0002, "sll_b_hi");
        step(OP_ALU_SRA, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321, "sra_0");

        // Undefined op code.
        step(6'd63, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, "undef_63");
        step(6'd10, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, "undef_10");

        // Reset asserted mid-stream, then recovery.
        step(OP_ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, "pre_rst");
        reset_cycles(1, OP_ALU_SUB, 32'd0, 32'd1, "mid_reset");
        step(OP_ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, "post_rst");

        // Randomized stream: a new op every cycle, checked against the model.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       b = a;
                1:       b = 32'd0;
                2:       b = {27'($urandom), 5'd31};
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(10, 63));
            else                            op = 6'($urandom_range(0, 9));
            step(op, a, b, ref_alu(op, a, b), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
